// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, downstream
// hold, and saturating bubble/flush performance counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_ALUSrc,
  input  logic              id_RegDst,
  input  logic              id_Branch,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  output logic              hazard_detected,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ex_valid,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Everything the EX register carries, so a bubble is a single all-zero load.
  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              reg_dst;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } ex_reg_t;

  ex_reg_t ex_q, id_d;

  assign id_d = '{valid: id_valid, alu_op: id_ALUOp, alu_src: id_ALUSrc,
                  reg_dst: id_RegDst, branch: id_Branch, mem_read: id_MemRead,
                  mem_write: id_MemWrite, reg_write: id_RegWrite,
                  mem_to_reg: id_MemtoReg, rs: id_rs, rt: id_rt, rd: id_rd,
                  rd1: id_rd1, rd2: id_rd2, imm: id_imm, pc4: id_pc4};

  // $zero is never a real dependency, so a load into r0 never stalls.
  assign hazard_detected = ex_q.valid & ex_q.mem_read & id_valid &
                           (ex_q.rt != '0) &
                           ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));
  assign pc_write   = ~(hazard_detected | hold);
  assign ifid_write = ~(hazard_detected | hold);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush) begin
      ex_q <= '0;
      if (id_valid && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end else if (hold) begin
      ex_q <= ex_q;
    end else if (hazard_detected) begin
      ex_q <= '0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      ex_q <= id_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_ALUOp    = ex_q.alu_op;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_RegDst   = ex_q.reg_dst;
  assign ex_Branch   = ex_q.branch;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemtoReg = ex_q.mem_to_reg;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_pc4      = ex_q.pc4;

endmodule
